// File: rtl/block_memory.sv
// Main-memory model behind the L2 memory port: whole-block storage, posted
// single-cycle writes, and block reads returned after a fixed latency.
module block_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int BLOCK_SIZE   = 32,
  parameter int READ_LATENCY = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                  mem_ready
);

  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int INDEX_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int NUM_BLOCKS   = 2 ** INDEX_WIDTH;
  localparam logic [3:0] COUNT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    COOLDOWN
  } state_t;

  state_t                                  state_reg;
  logic [3:0]                              count_reg;
  logic [INDEX_WIDTH-1:0]                  index_reg;
  logic                                    ready_reg;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   block_reg;

  logic [INDEX_WIDTH-1:0]                  addr_index;
  logic                                    write_en;
  logic                                    fwd_hit;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]   read_block;
  logic                                    unused_offset;

  assign addr_index    = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign unused_offset = ^mem_addr[OFFSET_WIDTH-1:0];

  // A write sampled together with reset is dropped.
  assign write_en = mem_write & rst_n;
  // Write-first: a write landing on the response edge to the pending index wins.
  assign fwd_hit  = write_en && (addr_index == index_reg);

  // One bank per word lane; storage starts at zero and ignores reset.
  generate
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : gen_bank
      logic [DATA_WIDTH-1:0] bank [NUM_BLOCKS] = '{default: '0};

      always_ff @(posedge clk) begin
        if (write_en) begin
          bank[addr_index] <= mem_data_out[gi];
        end
      end

      assign read_block[gi] = fwd_hit ? mem_data_out[gi] : bank[index_reg];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= '0;
      ready_reg <= 1'b0;
      block_reg <= '0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_read) begin
            index_reg <= addr_index;
            count_reg <= COUNT_LOAD;
            state_reg <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (count_reg == 4'd0) begin
            block_reg <= read_block;
            ready_reg <= 1'b1;
            state_reg <= COOLDOWN;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        // Swallows the extra cycle the L2 keeps mem_read high after mem_ready.
        COOLDOWN: state_reg <= IDLE;
        default:  state_reg <= IDLE;
      endcase
    end
  end

  assign mem_data_block = block_reg;
  assign mem_ready      = ready_reg;

endmodule

// File: tb/tb_block_memory.sv
// Scoreboard bench for block_memory: a latency-4 instance for function and
// timing, and a latency-1 instance on the same inputs for back-to-back spacing.
module tb_block_memory;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 32;
  localparam int NB = 64;

  typedef logic [BS-1:0][DW-1:0] block_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  block_t        mem_data_out;
  logic          mem_read;
  logic          mem_write;
  block_t        data0, data1;
  logic          ready0, ready1;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  block_t exp_q[$];
  block_t model_mem[NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .READ_LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_block(data0), .mem_ready(ready0)
  );

  block_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .READ_LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_block(data1), .mem_ready(ready1)
  );

  function automatic block_t fill_inc(logic [DW-1:0] base);
    block_t b;
    for (int i = 0; i < BS; i++) b[i] = base + DW'(i);
    return b;
  endfunction

  function automatic block_t fill_const(logic [DW-1:0] v);
    block_t b;
    for (int i = 0; i < BS; i++) b[i] = v;
    return b;
  endfunction

  function automatic int first_diff(block_t a, block_t b);
    for (int i = 0; i < BS; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output block_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
  endtask

  // Holds mem_read until mem_ready, keeps it one extra cycle, then idles.
  // write_at = k drives a write sampled k edges after acceptance (-1: none).
  task automatic issue_read(input logic [AW-1:0] raddr, input int write_at,
                            input logic [AW-1:0] waddr, input block_t wdata,
                            output int lat, output block_t blk,
                            output logic seen, output int late_pulses);
    int acc;
    seen = 1'b0; lat = -1; blk = '0; late_pulses = 0;
    mem_read = 1'b1;
    mem_addr = raddr;
    if (write_at == 0) begin
      mem_write = 1'b1; mem_addr = waddr; mem_data_out = wdata;
    end
    step();
    acc = cyc;
    mem_write = 1'b0;
    mem_addr = raddr;
    for (int i = 1; i <= 30 && !seen; i++) begin
      if (i == write_at) begin
        mem_write = 1'b1; mem_addr = waddr; mem_data_out = wdata;
      end
      step();
      mem_write = 1'b0;
      mem_addr = raddr;
      if (ready0 === 1'b1) begin
        seen = 1'b1; lat = cyc - acc; blk = data0;
      end
    end
    step();
    if (ready0 !== 1'b0) late_pulses++;
    mem_read = 1'b0;
    repeat (6) begin
      step();
      if (ready0 !== 1'b0) late_pulses++;
    end
  endtask

  task automatic test_reset();
    int lat, late, k;
    logic seen;
    block_t blk, e;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data_out = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (ready0 !== 1'b0 || data0 !== '0) begin
        n_bad++;
        $display("FAIL reset_idle: cycle %0d ready=%b word0=%h, want ready=0 data=0", i, ready0, data0[0]);
      end
    end
    exp_q.push_back(model_mem[0]);
    issue_read(11'h000, -1, '0, '0, lat, blk, seen, late);
    pop_exp(e);
    n_cmp++;
    if (!seen || lat != 4) begin
      n_bad++; $display("FAIL reset_read_lat: seen=%b latency %0d, want 4", seen, lat);
    end
    n_cmp++;
    if (blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL reset_read_data: word %0d got %h want %h", k, blk[k], e[k]);
    end
    $display("read 0x000: latency %0d word0 %h", lat, blk[0]);
  endtask

  task automatic test_write_read();
    int lat, late, k;
    logic seen;
    block_t blk, e, wd;
    wd = fill_inc(32'h100);
    mem_write = 1'b1; mem_addr = 11'h0A0; mem_data_out = wd;
    step();
    mem_write = 1'b0;
    model_mem[5] = wd;
    exp_q.push_back(model_mem[5]);
    issue_read(11'h0A0, -1, '0, '0, lat, blk, seen, late);
    pop_exp(e);
    n_cmp++;
    if (!seen || lat != 4) begin
      n_bad++; $display("FAIL wr_rd_lat: seen=%b latency %0d, want 4", seen, lat);
    end
    n_cmp++;
    if (blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL wr_rd_data: word %0d got %h want %h", k, blk[k], e[k]);
    end
    n_cmp++;
    if (late != 0) begin
      n_bad++; $display("FAIL wr_rd_single_pulse: %0d extra ready cycles, want 0", late);
    end
    $display("write+read block 5: latency %0d word31 %h", lat, blk[BS-1]);
  endtask

  task automatic test_forwarding();
    int lat, late, k;
    logic seen;
    block_t blk, e, db, other;
    db = fill_const(32'hDEADBEEF);
    // Write during READ_WAIT (offset bits differ, same block).
    exp_q.push_back(db);
    issue_read(11'h0A0, 2, 11'h0BF, db, lat, blk, seen, late);
    model_mem[5] = db;
    pop_exp(e);
    n_cmp++;
    if (!seen || blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL fwd_wait_data: seen=%b word %0d got %h want %h", seen, k, blk[k], e[k]);
    end
    $display("read with write in READ_WAIT: word0 %h", blk[0]);
    // Store something else, then write DEADBEEF on the response edge itself.
    other = fill_inc(32'h200);
    mem_write = 1'b1; mem_addr = 11'h0A0; mem_data_out = other;
    step();
    mem_write = 1'b0;
    exp_q.push_back(db);
    issue_read(11'h0A0, 4, 11'h0A0, db, lat, blk, seen, late);
    model_mem[5] = db;
    pop_exp(e);
    n_cmp++;
    if (!seen || lat != 4) begin
      n_bad++; $display("FAIL fwd_resp_lat: seen=%b latency %0d, want 4", seen, lat);
    end
    n_cmp++;
    if (blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL fwd_resp_data: word %0d got %h want %h", k, blk[k], e[k]);
    end
    $display("read with write on response edge: word0 %h", blk[0]);
  endtask

  task automatic test_read_write_same_cycle();
    int lat, late, k;
    logic seen;
    block_t blk, e, wd;
    wd = fill_inc(32'hA5A50000);
    exp_q.push_back(wd);
    issue_read(11'h7E7, 0, 11'h7E7, wd, lat, blk, seen, late);
    model_mem[63] = wd;
    pop_exp(e);
    n_cmp++;
    if (!seen || lat != 4 || blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL rw_same_cycle: seen=%b lat %0d word %0d got %h want %h", seen, lat, k, blk[k], e[k]);
    end
    exp_q.push_back(model_mem[63]);
    issue_read(11'h7FF, -1, '0, '0, lat, blk, seen, late);
    pop_exp(e);
    n_cmp++;
    if (!seen || blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL top_index_offset: word %0d got %h want %h", k, blk[k], e[k]);
    end
    $display("read+write block 63: word1 %h", blk[1]);
  endtask

  task automatic test_reset_mid_read();
    int lat, late, k, bad_cycles;
    logic seen;
    block_t blk, e;
    mem_read = 1'b1; mem_addr = 11'h0A0;
    step();
    step();
    rst_n = 1'b0; mem_read = 1'b0;
    mem_write = 1'b1; mem_data_out = fill_const(32'h0BADF00D);
    step();
    rst_n = 1'b1; mem_write = 1'b0;
    bad_cycles = 0;
    repeat (8) begin
      step();
      if (ready0 !== 1'b0 || data0 !== '0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++; $display("FAIL reset_mid_read: %0d cycles with ready/data nonzero, want 0", bad_cycles);
    end
    exp_q.push_back(model_mem[5]);
    issue_read(11'h0A0, -1, '0, '0, lat, blk, seen, late);
    pop_exp(e);
    n_cmp++;
    if (!seen || lat != 4) begin
      n_bad++; $display("FAIL post_reset_lat: seen=%b latency %0d, want 4", seen, lat);
    end
    n_cmp++;
    if (blk !== e) begin
      k = first_diff(blk, e); n_bad++;
      $display("FAIL post_reset_data: word %0d got %h want %h", k, blk[k], e[k]);
    end
    $display("reset mid-read then read: latency %0d word0 %h", lat, blk[0]);
  endtask

  task automatic test_back_to_back();
    int p1[$];
    int p0[$];
    int exp1[4] = '{1, 4, 7, 10};
    int acc, k;
    block_t e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[5]);
    mem_read = 1'b1; mem_addr = 11'h0A0;
    step();
    acc = cyc;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (ready1 === 1'b1) begin
        p1.push_back(cyc - acc);
        pop_exp(e);
        n_cmp++;
        if (data1 !== e) begin
          k = first_diff(data1, e); n_bad++;
          $display("FAIL b2b_data: word %0d got %h want %h", k, data1[k], e[k]);
        end
      end
      if (ready0 === 1'b1) p0.push_back(cyc - acc);
    end
    mem_read = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (p1.size() != 4) begin
      n_bad++; $display("FAIL b2b_lat1_count: got %0d pulses want 4", p1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (p1[i] != exp1[i]) begin
          n_bad++; $display("FAIL b2b_lat1_pulse%0d: at cycle %0d want %0d", i, p1[i], exp1[i]);
        end
      end
    end
    n_cmp++;
    if (p0.size() != 2 || p0[0] != 4 || p0[1] != 10) begin
      n_bad++; $display("FAIL b2b_lat4_spacing: %0d pulses, want pulses at 4 and 10", p0.size());
    end
    $display("back-to-back: lat1 pulses %0d, lat4 pulses %0d", p1.size(), p0.size());
  endtask

  initial begin
    for (int i = 0; i < NB; i++) model_mem[i] = '0;
    test_reset();
    test_write_read();
    test_forwarding();
    test_read_write_same_cycle();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
